// File: rtl/hazard_fwd_ctrl_pkg.sv
// rtl/hazard_fwd_ctrl_pkg.sv - shared types, constants and helpers for the hazard/forwarding controller
package hazard_fwd_pkg;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    // fwd_sel code meaning "take the operand from the register file"
    localparam int FWD_SEL_RF = 0;

    // Width of one fwd_sel field: regfile plus one code per forwarding stage
    function automatic int fwd_sel_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// rtl/hazard_fwd_ctrl_if.sv - pipeline-side signal bundle of the hazard/forwarding controller
//  slave  : controller view (pipeline status in, stall/flush/forward controls out)
//  master : pipeline view (drives status, receives controls)
interface hazard_fwd_ctrl_if
    import hazard_fwd_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int NUM_FWD_STG = 2,
    parameter int NUM_MC      = 2,
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32
);
    localparam int FSW = fwd_sel_w(NUM_FWD_STG);

    logic [NUM_SRC*REG_AW-1:0]     exe_rs_addr_i;
    logic [NUM_SRC-1:0]            exe_use_rs_i;
    logic                          exe_new_pc_req_i;
    logic [NUM_FWD_STG*REG_AW-1:0] stg_rd_addr_i;
    logic [NUM_FWD_STG-1:0]        stg_rd_wr_i;
    logic [NUM_FWD_STG-1:0]        stg_late_i;
    logic [NUM_MC-1:0]             mc_req_i;
    logic [NUM_MC-1:0]             mc_ack_i;
    logic                          store_busy_i;
    logic                          csr_new_pc_i;
    logic                          csr_wfi_i;
    logic                          csr_irq_flush_i;

    logic [NUM_SRC*FSW-1:0]        fwd_sel_o;
    logic                          front_stall_o;
    logic                          exe2lsu_stall_o;
    logic                          if2id_flush_o;
    logic                          id2exe_flush_o;
    logic                          exe2lsu_flush_o;
    logic                          lsu2wrb_flush_o;
    logic                          lsu_flush_o;
    logic                          exe_new_pc_o;
    logic                          csr_new_pc_o;
    logic                          wfi_o;
    logic                          pipe_stall_d_o;
    logic [NUM_MC-1:0]             mc_busy_o;
    logic [CNT_W-1:0]              stall_cycles_o;
    logic [NUM_MC-1:0]             wdog_err_o;

    modport slave (
        input  exe_rs_addr_i, exe_use_rs_i, exe_new_pc_req_i, stg_rd_addr_i, stg_rd_wr_i,
               stg_late_i, mc_req_i, mc_ack_i, store_busy_i, csr_new_pc_i, csr_wfi_i,
               csr_irq_flush_i,
        output fwd_sel_o, front_stall_o, exe2lsu_stall_o, if2id_flush_o, id2exe_flush_o,
               exe2lsu_flush_o, lsu2wrb_flush_o, lsu_flush_o, exe_new_pc_o, csr_new_pc_o,
               wfi_o, pipe_stall_d_o, mc_busy_o, stall_cycles_o, wdog_err_o
    );

    modport master (
        output exe_rs_addr_i, exe_use_rs_i, exe_new_pc_req_i, stg_rd_addr_i, stg_rd_wr_i,
               stg_late_i, mc_req_i, mc_ack_i, store_busy_i, csr_new_pc_i, csr_wfi_i,
               csr_irq_flush_i,
        input  fwd_sel_o, front_stall_o, exe2lsu_stall_o, if2id_flush_o, id2exe_flush_o,
               exe2lsu_flush_o, lsu2wrb_flush_o, lsu_flush_o, exe_new_pc_o, csr_new_pc_o,
               wfi_o, pipe_stall_d_o, mc_busy_o, stall_cycles_o, wdog_err_o
    );

endinterface

// File: rtl/hazard_fwd_ctrl_mc_stall_tracker.sv
// rtl/hazard_fwd_ctrl_mc_stall_tracker.sv - IDLE/BUSY tracker for one multi-cycle unit, optional watchdog (HAZARD_WDOG_EN)
//  clk, rst    : clock, asynchronous active-high reset
//  req, ack    : unit request / completion
//  flush       : pipeline redirect; forces IDLE on the next edge, overriding req
//  stall_next  : combinational stall for the current cycle (next state is BUSY)
//  busy        : registered state == MC_BUSY
//  wdog_err    : sticky watchdog error (always 0 without HAZARD_WDOG_EN)
module mc_stall_tracker
    import hazard_fwd_pkg::*;
#(
    parameter int WDOG_CYCLES = 1024
)(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    input  logic flush,
    output logic stall_next,
    output logic busy,
    output logic wdog_err
);
    mc_state_e state_q, state_d;
    logic      ack_eff;

`ifdef HAZARD_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt;
    logic          wdog_hit;
    logic          err_q;

    // Once the count has reached the limit the unit is released as if it had acked
    assign wdog_hit = (state_q == MC_BUSY) && (wdog_cnt == WW'(WDOG_CYCLES));
    assign ack_eff  = ack | wdog_hit;
    assign wdog_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
            err_q    <= 1'b0;
        end else if ((state_q == MC_BUSY) && (state_d == MC_BUSY)) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WW'(WDOG_CYCLES - 1)) begin
                err_q <= 1'b1;
            end
        end else begin
            wdog_cnt <= '0;
        end
    end
`else
    assign ack_eff  = ack;
    assign wdog_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ack beats req, so a same-cycle req/ack never enters BUSY
    always_comb begin
        stall_next = 1'b0;
        state_d    = MC_IDLE;
        if (ack_eff) begin
            stall_next = 1'b0;
        end else if (req) begin
            stall_next = 1'b1;
        end else begin
            stall_next = (state_q == MC_BUSY);
        end
        if (stall_next && !flush) begin
            state_d = MC_BUSY;
        end
    end

    assign busy = (state_q == MC_BUSY);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - pipeline hazard detection, operand forwarding select and stall/flush/redirect control
//  Optional watchdog per multi-cycle unit: define HAZARD_WDOG_EN.
//  clk, rst : clock, asynchronous active-high reset
//  bus      : hazard_fwd_ctrl_if.slave - EXE sources, stage destinations, multi-cycle req/ack,
//             CSR redirects in; fwd_sel, stalls, flushes, redirects, busy/counter/error out
module hazard_fwd_ctrl
    import hazard_fwd_pkg::*;
#(
    parameter int NUM_SRC     = 2,
    parameter int NUM_FWD_STG = 2,
    parameter int NUM_MC      = 2,
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1024
)(
    input  logic              clk,
    input  logic              rst,
    hazard_fwd_ctrl_if.slave  bus
);
    localparam int FSW = fwd_sel_w(NUM_FWD_STG);

    logic [NUM_SRC*FSW-1:0] fwd_sel;
    logic [NUM_SRC-1:0]     hazard;
    logic [NUM_MC-1:0]      stall_next;
    logic [NUM_MC-1:0]      mc_busy;
    logic [NUM_MC-1:0]      wdog_err;
    logic                   mc_stall;
    logic                   raw_hazard;
    logic                   lsu_flush;
    logic                   exe_new_pc;
    logic                   front_stall;
    logic                   pipe_stall_d_q;
    logic [CNT_W-1:0]       stall_cnt_q;

    // Scan stages oldest to youngest so the nearest matching stage is the last to write sel.
    // x0 never forwards. A late winner still drives sel; EXE ignores it while stalled.
    always_comb begin
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rd;
        logic [FSW-1:0]    sel;
        logic              late;
        fwd_sel = '0;
        hazard  = '0;
        rs      = '0;
        rd      = '0;
        sel     = '0;
        late    = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            rs   = bus.exe_rs_addr_i[s*REG_AW +: REG_AW];
            sel  = FSW'(FWD_SEL_RF);
            late = 1'b0;
            for (int k = NUM_FWD_STG - 1; k >= 0; k--) begin
                rd = bus.stg_rd_addr_i[k*REG_AW +: REG_AW];
                if (bus.stg_rd_wr_i[k] && (rd == rs) && (rs != '0)) begin
                    sel  = FSW'(k + 1);
                    late = bus.stg_late_i[k];
                end
            end
            fwd_sel[s*FSW +: FSW] = sel;
            hazard[s]             = bus.exe_use_rs_i[s] & late;
        end
    end

    for (genvar k = 0; k < NUM_MC; k++) begin : g_mc
        mc_stall_tracker #(
            .WDOG_CYCLES (WDOG_CYCLES)
        ) u_trk (
            .clk        (clk),
            .rst        (rst),
            .req        (bus.mc_req_i[k]),
            .ack        (bus.mc_ack_i[k]),
            .flush      (lsu_flush),
            .stall_next (stall_next[k]),
            .busy       (mc_busy[k]),
            .wdog_err   (wdog_err[k])
        );
    end

    // A multi-cycle stall already freezes EXE, so it masks the RAW hazard
    assign mc_stall    = |stall_next;
    assign raw_hazard  = (|hazard) & ~mc_stall;
    assign lsu_flush   = bus.csr_new_pc_i | bus.csr_wfi_i;
    assign exe_new_pc  = bus.exe_new_pc_req_i & ~raw_hazard & ~mc_stall & ~bus.csr_new_pc_i;
    assign front_stall = raw_hazard | mc_stall | bus.store_busy_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_stall_d_q <= 1'b0;
            stall_cnt_q    <= '0;
        end else begin
            pipe_stall_d_q <= mc_stall;
            if (front_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign bus.fwd_sel_o       = fwd_sel;
    assign bus.front_stall_o   = front_stall;
    assign bus.exe2lsu_stall_o = mc_stall;
    assign bus.if2id_flush_o   = exe_new_pc | lsu_flush;
    assign bus.id2exe_flush_o  = exe_new_pc | lsu_flush;
    assign bus.exe2lsu_flush_o = raw_hazard | lsu_flush;
    assign bus.lsu2wrb_flush_o = bus.csr_irq_flush_i;
    assign bus.lsu_flush_o     = lsu_flush;
    assign bus.exe_new_pc_o    = exe_new_pc;
    assign bus.csr_new_pc_o    = bus.csr_new_pc_i;
    assign bus.wfi_o           = bus.csr_wfi_i;
    assign bus.pipe_stall_d_o  = pipe_stall_d_q;
    assign bus.mc_busy_o       = mc_busy;
    assign bus.stall_cycles_o  = stall_cnt_q;
    assign bus.wdog_err_o      = wdog_err;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - directed scoreboard bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

    localparam int NUM_SRC     = 2;
    localparam int NUM_FWD_STG = 2;
    localparam int NUM_MC      = 2;
    localparam int REG_AW      = 5;
    localparam int CNT_W       = 4;
    localparam int WDOG_CYCLES = 16;

    typedef enum int {
        S_FWD0, S_FWD1, S_FSTALL, S_E2L_STALL, S_E2L_FLUSH, S_IF_FLUSH, S_ID_FLUSH,
        S_L2W_FLUSH, S_LSU_FLUSH, S_EXE_PC, S_CSR_PC, S_WFI, S_PSD, S_BUSY, S_CNT, S_WDOG
    } sig_e;

    typedef struct {
        string       tag;
        sig_e        id;
        logic [31:0] exp;
    } sb_t;

    logic clk;
    logic rst;
    sb_t  sb[$];
    int   n_vec;
    int   n_mis;
    logic exp_fs;
    logic [CNT_W-1:0] exp_cnt;

    hazard_fwd_ctrl_if #(
        .NUM_SRC(NUM_SRC), .NUM_FWD_STG(NUM_FWD_STG), .NUM_MC(NUM_MC),
        .REG_AW(REG_AW), .CNT_W(CNT_W)
    ) bus ();

    hazard_fwd_ctrl #(
        .NUM_SRC(NUM_SRC), .NUM_FWD_STG(NUM_FWD_STG), .NUM_MC(NUM_MC),
        .REG_AW(REG_AW), .CNT_W(CNT_W), .WDOG_CYCLES(WDOG_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference stall-cycle counter driven by the expected front_stall of each cycle
    always @(posedge clk or posedge rst) begin
        if (rst) exp_cnt <= '0;
        else if (exp_fs && exp_cnt != '1) exp_cnt <= exp_cnt + 1'b1;
    end

    function automatic logic [31:0] obs(input sig_e id);
        case (id)
            S_FWD0:      return 32'(bus.fwd_sel_o[1:0]);
            S_FWD1:      return 32'(bus.fwd_sel_o[3:2]);
            S_FSTALL:    return 32'(bus.front_stall_o);
            S_E2L_STALL: return 32'(bus.exe2lsu_stall_o);
            S_E2L_FLUSH: return 32'(bus.exe2lsu_flush_o);
            S_IF_FLUSH:  return 32'(bus.if2id_flush_o);
            S_ID_FLUSH:  return 32'(bus.id2exe_flush_o);
            S_L2W_FLUSH: return 32'(bus.lsu2wrb_flush_o);
            S_LSU_FLUSH: return 32'(bus.lsu_flush_o);
            S_EXE_PC:    return 32'(bus.exe_new_pc_o);
            S_CSR_PC:    return 32'(bus.csr_new_pc_o);
            S_WFI:       return 32'(bus.wfi_o);
            S_PSD:       return 32'(bus.pipe_stall_d_o);
            S_BUSY:      return 32'(bus.mc_busy_o);
            S_CNT:       return 32'(bus.stall_cycles_o);
            S_WDOG:      return 32'(bus.wdog_err_o);
            default:     return 32'hdead_beef;
        endcase
    endfunction

    task automatic push(input string tag, input sig_e id, input logic [31:0] exp);
        sb.push_back('{tag, id, exp});
    endtask

    task automatic drain();
        sb_t e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.id);
            n_vec++;
            assert (o === e.exp) else begin
                n_mis++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic clr_inputs();
        bus.exe_rs_addr_i    = '0;
        bus.exe_use_rs_i     = '0;
        bus.exe_new_pc_req_i = 1'b0;
        bus.stg_rd_addr_i    = '0;
        bus.stg_rd_wr_i      = '0;
        bus.stg_late_i       = '0;
        bus.mc_req_i         = '0;
        bus.mc_ack_i         = '0;
        bus.store_busy_i     = 1'b0;
        bus.csr_new_pc_i     = 1'b0;
        bus.csr_wfi_i        = 1'b0;
        bus.csr_irq_flush_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec  = 0;
        n_mis  = 0;
        exp_fs = 1'b0;
        rst    = 1'b1;
        clr_inputs();

        // Reset state
        @(negedge clk); #1;
        push("rst_busy", S_BUSY, 0);
        push("rst_cnt", S_CNT, 0);
        push("rst_psd", S_PSD, 0);
        push("rst_wdog", S_WDOG, 0);
        push("rst_fwd0", S_FWD0, 0);
        push("rst_fstall", S_FSTALL, 0);
        drain();
        @(negedge clk);
        rst = 1'b0;

        // Forward from LSU stage
        @(negedge clk);
        clr_inputs();
        bus.stg_rd_addr_i[4:0] = 5'd5; bus.stg_rd_wr_i = 2'b01;
        bus.exe_rs_addr_i[4:0] = 5'd5; bus.exe_use_rs_i = 2'b01;
        exp_fs = 1'b0;
        push("fwd_lsu_sel", S_FWD0, 1);
        push("fwd_lsu_stall", S_FSTALL, 0);
        #1 drain();

        // Forward from WRB stage
        @(negedge clk);
        bus.stg_rd_wr_i = 2'b10; bus.stg_rd_addr_i[9:5] = 5'd5;
        push("fwd_wrb_sel", S_FWD0, 2);
        #1 drain();

        // x0 never forwards, even on an address match
        @(negedge clk);
        bus.exe_rs_addr_i[4:0] = 5'd0; bus.stg_rd_addr_i = '0; bus.stg_rd_wr_i = 2'b11;
        push("fwd_x0_sel", S_FWD0, 0);
        #1 drain();

        // Youngest wins; a late older stage does not matter when it loses
        @(negedge clk);
        clr_inputs();
        bus.stg_rd_addr_i = {5'd7, 5'd7}; bus.stg_rd_wr_i = 2'b11; bus.stg_late_i = 2'b10;
        bus.exe_rs_addr_i[9:5] = 5'd7; bus.exe_use_rs_i = 2'b10;
        push("prio_sel", S_FWD1, 1);
        push("prio_stall", S_FSTALL, 0);
        #1 drain();

        // Load-use hazard with same-cycle req/ack on unit 0 and a branch redirect
        @(negedge clk);
        clr_inputs();
        bus.stg_rd_addr_i[4:0] = 5'd3; bus.stg_rd_wr_i = 2'b01; bus.stg_late_i = 2'b01;
        bus.exe_rs_addr_i[4:0] = 5'd3; bus.exe_use_rs_i = 2'b01;
        bus.mc_req_i = 2'b01; bus.mc_ack_i = 2'b01; bus.exe_new_pc_req_i = 1'b1;
        exp_fs = 1'b1;
        push("lu_fwd", S_FWD0, 1);
        push("lu_fstall", S_FSTALL, 1);
        push("lu_e2l_flush", S_E2L_FLUSH, 1);
        push("lu_e2l_stall", S_E2L_STALL, 0);
        push("lu_exe_pc", S_EXE_PC, 0);
        push("lu_if_flush", S_IF_FLUSH, 0);
        #1 drain();

        @(negedge clk);
        clr_inputs();
        bus.exe_new_pc_req_i = 1'b1;
        exp_fs = 1'b0;
        push("lu_after_busy", S_BUSY, 0);
        push("lu_after_exe_pc", S_EXE_PC, 1);
        push("lu_after_if_flush", S_IF_FLUSH, 1);
        push("lu_after_id_flush", S_ID_FLUSH, 1);
        push("lu_after_fstall", S_FSTALL, 0);
        #1 drain();

        // Divider: req at c0, ack at c5
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            clr_inputs();
            bus.mc_req_i = (c == 0) ? 2'b10 : 2'b00;
            bus.mc_ack_i = (c == 5) ? 2'b10 : 2'b00;
            exp_fs = (c <= 4);
            push($sformatf("div_stall_c%0d", c), S_E2L_STALL, (c <= 4) ? 1 : 0);
            push($sformatf("div_psd_c%0d", c), S_PSD, (c >= 1 && c <= 5) ? 1 : 0);
            push($sformatf("div_busy_c%0d", c), S_BUSY, (c >= 1 && c <= 5) ? 2 : 0);
            #1 drain();
        end

        // Divider cut short by a CSR redirect at c2
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            clr_inputs();
            bus.mc_req_i = (c == 0) ? 2'b10 : 2'b00;
            bus.csr_new_pc_i = (c == 2);
            exp_fs = (c <= 2);
            push($sformatf("divf_stall_c%0d", c), S_E2L_STALL, (c <= 2) ? 1 : 0);
            push($sformatf("divf_lsu_flush_c%0d", c), S_LSU_FLUSH, (c == 2) ? 1 : 0);
            if (c == 2) begin
                push("divf_csr_pc", S_CSR_PC, 1);
                push("divf_e2l_flush", S_E2L_FLUSH, 1);
                push("divf_if_flush", S_IF_FLUSH, 1);
            end
            if (c == 3) push("divf_busy_c3", S_BUSY, 0);
            #1 drain();
        end

        // WFI / IRQ flush pass-through
        @(negedge clk);
        clr_inputs();
        bus.csr_wfi_i = 1'b1; bus.csr_irq_flush_i = 1'b1;
        exp_fs = 1'b0;
        push("wfi_out", S_WFI, 1);
        push("wfi_lsu_flush", S_LSU_FLUSH, 1);
        push("wfi_l2w_flush", S_L2W_FLUSH, 1);
        push("wfi_e2l_flush", S_E2L_FLUSH, 1);
        push("wfi_csr_pc", S_CSR_PC, 0);
        push("stall_cnt", S_CNT, 32'(exp_cnt));
        #1 drain();

`ifdef HAZARD_WDOG_EN
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            clr_inputs();
            bus.mc_req_i = (c == 0) ? 2'b01 : 2'b00;
            exp_fs = (c <= 16);
            push($sformatf("wdog_err_c%0d", c), S_WDOG, (c >= 17) ? 1 : 0);
            push($sformatf("wdog_busy_c%0d", c), S_BUSY, (c >= 1 && c <= 17) ? 1 : 0);
            #1 drain();
        end
`else
        @(negedge clk);
        clr_inputs();
        bus.mc_req_i = 2'b01;
        push("wdog_off", S_WDOG, 0);
        #1 drain();
        @(negedge clk);
        clr_inputs();
        bus.mc_ack_i = 2'b01;
        exp_fs = 1'b0;
        #1 drain();
`endif

        // Store-busy stall only: counter saturates, FSMs untouched
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            clr_inputs();
            bus.store_busy_i = 1'b1;
            exp_fs = 1'b1;
        end
        @(negedge clk);
        clr_inputs();
        exp_fs = 1'b0;
        push("sat_cnt", S_CNT, 15);
        push("sat_busy", S_BUSY, 0);
        push("sat_e2l_stall", S_E2L_STALL, 0);
        #1 drain();

        // Asynchronous reset in the middle of a BUSY period
        @(negedge clk);
        bus.mc_req_i = 2'b10;
        exp_fs = 1'b1;
        @(negedge clk);
        bus.mc_req_i = 2'b00;
        @(negedge clk);
        push("pre_rst_busy", S_BUSY, 2);
        push("pre_rst_psd", S_PSD, 1);
        #1 drain();
        #2 rst = 1'b1;
        #1;
        push("arst_busy", S_BUSY, 0);
        push("arst_cnt", S_CNT, 0);
        push("arst_psd", S_PSD, 0);
        drain();
        exp_fs = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
